plot_scheduler: RTL and testbench
=================================

Name: plot_scheduler

Overview:
- Shares the single vga_adapter plot port (x, y, colour, plot) between three sources:
  - an internal screen-clear sweep;
  - the user cell-load path;
  - the simulation changed-cell path.
- Converts each accepted cell write (grid coordinates) into a CELL_SIZE x CELL_SIZE pixel block, plotted one pixel per clock.
- Sits between the control/simulation blocks and vga_adapter in main.

Parameters:
- CELL_SIZE, 4: pixels per cell side; legal 1..8.
- SCREEN_W, 160: screen width in pixels.
- SCREEN_H, 120: screen height in pixels.

Ports:
- clock  in  1  system clock (CLOCK_50).
- reset_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- clear_req  in  1  request full-screen clear to colour 3'b000.
- ld_valid  in  1  load-path write request.
- ld_x  in  8  load-path cell column.
- ld_y  in  8  load-path cell row.
- ld_colour  in  3  load-path cell colour.
- ld_ready  out  1  load path may hand off this cycle.
- sim_valid  in  1  simulation-path write request.
- sim_x  in  8  simulation-path cell column.
- sim_y  in  8  simulation-path cell row.
- sim_colour  in  3  simulation-path cell colour.
- sim_ready  out  1  simulation path may hand off this cycle.
- vga_x  out  8  pixel x to vga_adapter.
- vga_y  out  8  pixel y to vga_adapter.
- vga_colour  out  3  pixel colour to vga_adapter.
- vga_plot  out  1  pixel write strobe.
- busy  out  1  high whenever state != IDLE.
- err_oob  out  1  one-cycle pulse when an accepted cell lies fully off-screen.

Behaviour:

Reset:
- While reset_n=0: vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, err_oob=0, clear_pending=0.
- While reset_n=0, the state register is held at CLEAR_START.
- Reset mid-operation aborts any fill or sweep; the clear restarts from pixel (0,0).

States: CLEAR_START, CLEAR, IDLE, FILL.
- CLEAR_START: on the first edge with reset_n=1, load vga_x=0, vga_y=0, vga_colour=0, vga_plot=1; go to CLEAR.
- CLEAR: one pixel per edge, x fastest (x 0..SCREEN_W-1, then y+1).
  - After pixel (SCREEN_W-1, SCREEN_H-1) has been presented for one cycle, the next edge sets vga_plot=0 and goes to IDLE.
  - Exactly SCREEN_W*SCREEN_H plot cycles (19200 at defaults).
- IDLE: outputs only, all combinational:
  - ld_ready = IDLE & ~clear_req & ~clear_pending.
  - sim_ready = ld_ready & ~ld_valid.
- IDLE priority: clear (clear_req or clear_pending) > load > simulation.
  - Clear: on the edge, go to CLEAR_START semantics directly (vga_plot=1 at (0,0)) and clear clear_pending.
- Handshake: a transfer occurs on an edge where valid & ready = 1. Coordinates and colour are captured on that edge.
- Accepted cell (cx, cy), origin ox = cx*CELL_SIZE, oy = cy*CELL_SIZE:
  - Compute ox and oy at 11 bits; no truncation before the range check.
  - If ox >= SCREEN_W or oy >= SCREEN_H: stay in IDLE, vga_plot stays 0, err_oob=1 for exactly one cycle.
  - Otherwise, on the same edge, present pixel (ox, oy) with vga_plot=1 and go to FILL.
- FILL: offsets dx, dy in 0..CELL_SIZE-1, dx fastest; exactly CELL_SIZE*CELL_SIZE cycles in FILL including the first pixel.
  - Pixels with ox+dx >= SCREEN_W or oy+dy >= SCREEN_H keep their cycle but have vga_plot=0 (clipping).
  - The edge after the last pixel sets vga_plot=0 and goes to IDLE.
  - A new request can therefore be accepted no earlier than one idle cycle after a block.
- Latency: first pixel is visible in the cycle immediately after the accepting edge; block completes CELL_SIZE^2 cycles after acceptance.
- clear_req outside IDLE:
  - During FILL it sets clear_pending; the clear is serviced after FILL, ahead of ld/sim.
  - During CLEAR_START or CLEAR it is ignored; there is no restart.
- vga_x, vga_y and vga_colour hold their last values whenever vga_plot=0.
- Requesters must hold valid and data stable until ready; the block never drops a held request.

Test Plan:
- Reset then release -> vga_plot high for exactly 19200 consecutive cycles. First pixel (0,0), pixel 160 is (0,1), last pixel (159,119), all colour 0. Then busy=0 and ld_ready=1.
- IDLE, ld_valid with (2,3) colour 3'b111 -> accepted that edge. 16 plot cycles follow, x 8..11 fastest, y 12..15, colour 7. Then one idle cycle.
- ld_valid (1,1) and sim_valid (5,5) asserted together in IDLE -> load block (x 4..7, y 4..7) plotted first; sim_ready low throughout. Sim block (x 20..23, y 20..23) is accepted only after the load block returns to IDLE.
- clear_req pulsed during the 5th cycle of a FILL, with sim_valid held -> FILL finishes its 16 pixels, then the full 19200-pixel clear runs, then the sim block is accepted.
- ld_valid (40,0) at CELL_SIZE=4 -> handshake completes, err_oob=1 for one cycle, no vga_plot. With CELL_SIZE=7 and cell (22,0): 7 FILL rows, each with 6 plotted pixels (x 154..159) and 1 clipped cycle.
- reset_n low for one cycle in the middle of a FILL -> outputs zero during reset; the clear sweep restarts at (0,0) after release.

Source files
------------

// File: rtl/plot_scheduler.sv
// Shares the vga_adapter plot port between a full-screen clear sweep, the
// cell-load path and the simulation path, expanding each cell into a pixel block.
module plot_scheduler #(
  parameter int CELL_SIZE = 4,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear_req,
  input  logic       ld_valid,
  input  logic [7:0] ld_x,
  input  logic [7:0] ld_y,
  input  logic [2:0] ld_colour,
  output logic       ld_ready,
  input  logic       sim_valid,
  input  logic [7:0] sim_x,
  input  logic [7:0] sim_y,
  input  logic [2:0] sim_colour,
  output logic       sim_ready,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       err_oob
);

  typedef enum logic [1:0] {CLEAR_START, CLEAR, IDLE, FILL} state_e;

  localparam logic [10:0] CS_W   = 11'(CELL_SIZE);
  localparam logic [10:0] SW_W   = 11'(SCREEN_W);
  localparam logic [10:0] SH_W   = 11'(SCREEN_H);
  localparam logic [7:0]  X_LAST = 8'(SCREEN_W - 1);
  localparam logic [7:0]  Y_LAST = 8'(SCREEN_H - 1);
  localparam logic [3:0]  D_LAST = 4'(CELL_SIZE - 1);

  state_e      state_q, state_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [7:0]  vga_y_q, vga_y_d;
  logic [2:0]  vga_colour_q, vga_colour_d;
  logic        vga_plot_q, vga_plot_d;
  logic        err_oob_q, err_oob_d;
  logic        clear_pending_q, clear_pending_d;
  logic [10:0] ox_q, ox_d;
  logic [10:0] oy_q, oy_d;
  logic [3:0]  dx_q, dx_d;
  logic [3:0]  dy_q, dy_d;

  logic        take_ld;
  logic        take_sim;
  logic [7:0]  req_x;
  logic [7:0]  req_y;
  logic [2:0]  req_colour;
  logic [10:0] req_ox;
  logic [10:0] req_oy;
  logic        req_oob;

  logic        fill_last;
  logic [3:0]  dx_nx;
  logic [3:0]  dy_nx;
  logic [10:0] px_nx;
  logic [10:0] py_nx;
  logic        nx_visible;

  // Handshake: load wins over simulation, and any clear request blocks both.
  assign ld_ready  = (state_q == IDLE) && !clear_req && !clear_pending_q;
  assign sim_ready = ld_ready && !ld_valid;
  assign take_ld   = ld_valid && ld_ready;
  assign take_sim  = sim_valid && sim_ready;

  assign req_x      = take_ld ? ld_x      : sim_x;
  assign req_y      = take_ld ? ld_y      : sim_y;
  assign req_colour = take_ld ? ld_colour : sim_colour;

  // Origin kept at 11 bits so cells far off-screen are not aliased back on.
  assign req_ox  = 11'(req_x) * CS_W;
  assign req_oy  = 11'(req_y) * CS_W;
  assign req_oob = (req_ox >= SW_W) || (req_oy >= SH_W);

  assign fill_last  = (dx_q == D_LAST) && (dy_q == D_LAST);
  assign dx_nx      = (dx_q == D_LAST) ? 4'd0 : dx_q + 4'd1;
  assign dy_nx      = (dx_q == D_LAST) ? dy_q + 4'd1 : dy_q;
  assign px_nx      = ox_q + 11'(dx_nx);
  assign py_nx      = oy_q + 11'(dy_nx);
  assign nx_visible = (px_nx < SW_W) && (py_nx < SH_W);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d         = state_q;
    vga_x_d         = vga_x_q;
    vga_y_d         = vga_y_q;
    vga_colour_d    = vga_colour_q;
    vga_plot_d      = 1'b0;
    err_oob_d       = 1'b0;
    clear_pending_d = clear_pending_q;
    ox_d            = ox_q;
    oy_d            = oy_q;
    dx_d            = dx_q;
    dy_d            = dy_q;

    unique case (state_q)
      CLEAR_START: begin
        vga_x_d      = 8'd0;
        vga_y_d      = 8'd0;
        vga_colour_d = 3'd0;
        vga_plot_d   = 1'b1;
        state_d      = CLEAR;
      end

      CLEAR: begin
        if (vga_x_q == X_LAST) begin
          if (vga_y_q == Y_LAST) begin
            state_d = IDLE;
          end else begin
            vga_x_d    = 8'd0;
            vga_y_d    = vga_y_q + 8'd1;
            vga_plot_d = 1'b1;
          end
        end else begin
          vga_x_d    = vga_x_q + 8'd1;
          vga_plot_d = 1'b1;
        end
      end

      IDLE: begin
        if (clear_req || clear_pending_q) begin
          vga_x_d         = 8'd0;
          vga_y_d         = 8'd0;
          vga_colour_d    = 3'd0;
          vga_plot_d      = 1'b1;
          clear_pending_d = 1'b0;
          state_d         = CLEAR;
        end else if (take_ld || take_sim) begin
          if (req_oob) begin
            err_oob_d = 1'b1;
          end else begin
            ox_d         = req_ox;
            oy_d         = req_oy;
            dx_d         = 4'd0;
            dy_d         = 4'd0;
            vga_x_d      = req_ox[7:0];
            vga_y_d      = req_oy[7:0];
            vga_colour_d = req_colour;
            vga_plot_d   = 1'b1;
            state_d      = FILL;
          end
        end
      end

      FILL: begin
        clear_pending_d = clear_pending_q || clear_req;
        if (fill_last) begin
          state_d = IDLE;
        end else begin
          dx_d = dx_nx;
          dy_d = dy_nx;
          // Clipped pixels still take their cycle; coordinates hold.
          if (nx_visible) begin
            vga_x_d    = px_nx[7:0];
            vga_y_d    = py_nx[7:0];
            vga_plot_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (!reset_n) begin
      state_q         <= CLEAR_START;
      vga_x_q         <= 8'd0;
      vga_y_q         <= 8'd0;
      vga_colour_q    <= 3'd0;
      vga_plot_q      <= 1'b0;
      err_oob_q       <= 1'b0;
      clear_pending_q <= 1'b0;
      ox_q            <= 11'd0;
      oy_q            <= 11'd0;
      dx_q            <= 4'd0;
      dy_q            <= 4'd0;
    end else begin
      state_q         <= state_d;
      vga_x_q         <= vga_x_d;
      vga_y_q         <= vga_y_d;
      vga_colour_q    <= vga_colour_d;
      vga_plot_q      <= vga_plot_d;
      err_oob_q       <= err_oob_d;
      clear_pending_q <= clear_pending_d;
      ox_q            <= ox_d;
      oy_q            <= oy_d;
      dx_q            <= dx_d;
      dy_q            <= dy_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign err_oob    = err_oob_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_plot_scheduler.sv
// Self-checking bench for plot_scheduler: a default instance for sweep, arbitration,
// clear and random cell traffic, plus a CELL_SIZE=7 instance for clipping.
module tb_plot_scheduler;

  localparam int CS = 4;
  localparam int SW = 160;
  localparam int SH = 120;

  logic       clock;
  logic       rst_n;
  logic       clear_req;
  logic       ld_valid;
  logic [7:0] ld_x;
  logic [7:0] ld_y;
  logic [2:0] ld_colour;
  logic       ld_ready;
  logic       sim_valid;
  logic [7:0] sim_x;
  logic [7:0] sim_y;
  logic [2:0] sim_colour;
  logic       sim_ready;
  logic [7:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       err_oob;

  logic       r7_n;
  logic       ld7_valid;
  logic [7:0] ld7_x;
  logic [7:0] ld7_y;
  logic [2:0] ld7_colour;
  logic       ld7_ready;
  logic       sim7_ready;
  logic [7:0] v7_x;
  logic [7:0] v7_y;
  logic [2:0] v7_colour;
  logic       v7_plot;
  logic       busy7;
  logic       err7;

  int n_checks = 0;
  int n_bad    = 0;

  // Last plotted pixel per instance: outputs hold these while vga_plot=0.
  int mdl_x, mdl_y, mdl_c;
  int m7x, m7y, m7c;
  int obs_row[7];
  int exp_row[7];

  plot_scheduler dut (
    .clock(clock), .reset_n(rst_n), .clear_req(clear_req),
    .ld_valid(ld_valid), .ld_x(ld_x), .ld_y(ld_y), .ld_colour(ld_colour), .ld_ready(ld_ready),
    .sim_valid(sim_valid), .sim_x(sim_x), .sim_y(sim_y), .sim_colour(sim_colour),
    .sim_ready(sim_ready), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .err_oob(err_oob)
  );

  plot_scheduler #(.CELL_SIZE(7), .SCREEN_W(SW), .SCREEN_H(SH)) dut7 (
    .clock(clock), .reset_n(r7_n), .clear_req(1'b0),
    .ld_valid(ld7_valid), .ld_x(ld7_x), .ld_y(ld7_y), .ld_colour(ld7_colour), .ld_ready(ld7_ready),
    .sim_valid(1'b0), .sim_x(8'd0), .sim_y(8'd0), .sim_colour(3'd0),
    .sim_ready(sim7_ready), .vga_x(v7_x), .vga_y(v7_y), .vga_colour(v7_colour),
    .vga_plot(v7_plot), .busy(busy7), .err_oob(err7)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int plot, input int x, input int y, input int c,
                                       input int bsy, input int lr, input int sr, input int err);
    return {8'd0, plot[0], x[7:0], y[7:0], c[2:0], bsy[0], lr[0], sr[0], err[0]};
  endfunction

  function automatic logic [31:0] obs();
    return {8'd0, vga_plot, vga_x, vga_y, vga_colour, busy, ld_ready, sim_ready, err_oob};
  endfunction

  function automatic logic [31:0] obs7();
    return {8'd0, v7_plot, v7_x, v7_y, v7_colour, busy7, ld7_ready, sim7_ready, err7};
  endfunction

  // Reference: k-th cycle of a block walks dx fastest over a cs x cs square.
  function automatic void cell_pixel(input int cs, input int cx, input int cy, input int k,
                                     output bit vis, output int px, output int py);
    px  = cx * cs + k % cs;
    py  = cy * cs + k / cs;
    vis = (px < SW) && (py < SH);
  endfunction

  function automatic bit cell_oob(input int cs, input int cx, input int cy);
    return (cx * cs >= SW) || (cy * cs >= SH);
  endfunction

  task automatic wait_accept(input string tag, output int cyc, output bit was_ld);
    bit fired;
    fired  = 1'b0;
    cyc    = 0;
    was_ld = 1'b0;
    for (int i = 0; i < 64 && !fired; i++) begin
      @(negedge clock);
      cyc++;
      if (ld_valid && ld_ready) begin
        fired  = 1'b1;
        was_ld = 1'b1;
      end else if (sim_valid && sim_ready) begin
        fired = 1'b1;
      end
    end
    if (!fired) check({tag, "_timeout"}, 32'd0, 32'd1);
    @(posedge clock); #1;
    if (fired && was_ld) ld_valid = 1'b0;
    else if (fired) sim_valid = 1'b0;
  endtask

  task automatic watch_block(input string tag, input int cx, input int cy, input int col,
                             input int n, input int clr_at);
    bit vis;
    int px, py;
    for (int k = 0; k < n; k++) begin
      clear_req = (k == clr_at);
      @(negedge clock);
      cell_pixel(CS, cx, cy, k, vis, px, py);
      if (vis) begin
        mdl_x = px; mdl_y = py; mdl_c = col;
      end
      check($sformatf("%s_k%0d", tag, k), obs(), pack(int'(vis), mdl_x, mdl_y, mdl_c, 1, 0, 0, 0));
      @(posedge clock); #1;
    end
    clear_req = 1'b0;
  endtask

  task automatic watch_clear(input string tag);
    int errs;
    logic [31:0] e;
    errs = 0;
    for (int k = 0; k < SW * SH; k++) begin
      @(negedge clock);
      e = pack(1, k % SW, k / SW, 0, 1, 0, 0, 0);
      if (obs() !== e) errs++;
      if (k == 0 || k == SW || k == SW * SH - 1) check($sformatf("%s_px%0d", tag, k), obs(), e);
      @(posedge clock); #1;
    end
    check({tag, "_sweep_errs"}, errs, 0);
    mdl_x = SW - 1; mdl_y = SH - 1; mdl_c = 0;
  endtask

  task automatic check_idle(input string tag, input int lr, input int sr);
    @(negedge clock);
    check(tag, obs(), pack(0, mdl_x, mdl_y, mdl_c, 0, lr, sr, 0));
    @(posedge clock); #1;
  endtask

  task automatic do_cell(input string tag, input bit use_sim, input int cx, input int cy, input int col);
    int cyc;
    bit was_ld;
    if (use_sim) begin
      sim_valid = 1'b1; sim_x = 8'(cx); sim_y = 8'(cy); sim_colour = 3'(col);
    end else begin
      ld_valid = 1'b1; ld_x = 8'(cx); ld_y = 8'(cy); ld_colour = 3'(col);
    end
    wait_accept(tag, cyc, was_ld);
    check({tag, "_acc"}, cyc * 2 + int'(was_ld), use_sim ? 2 : 3);
    if (cell_oob(CS, cx, cy)) begin
      @(negedge clock);
      check({tag, "_oob"}, obs(), pack(0, mdl_x, mdl_y, mdl_c, 0, 1, 1, 1));
      @(posedge clock); #1;
      check_idle({tag, "_oob_end"}, 1, 1);
    end else begin
      watch_block(tag, cx, cy, col, CS * CS, -1);
      check_idle({tag, "_end"}, 1, 1);
    end
  endtask

  int  cyc;
  bit  was_ld;
  bit  vis;
  int  px, py;
  int  r_s, r_x, r_y, r_c;

  initial begin
    rst_n = 1'b0; r7_n = 1'b0; clear_req = 1'b0;
    ld_valid = 1'b0; ld_x = '0; ld_y = '0; ld_colour = '0;
    sim_valid = 1'b0; sim_x = '0; sim_y = '0; sim_colour = '0;
    ld7_valid = 1'b0; ld7_x = '0; ld7_y = '0; ld7_colour = '0;
    mdl_x = 0; mdl_y = 0; mdl_c = 0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_state", obs(), pack(0, 0, 0, 0, 1, 0, 0, 0));
    rst_n = 1'b1; r7_n = 1'b1;
    @(posedge clock); #1;
    watch_clear("clr_init");
    check_idle("init_idle", 1, 1);
    check("dut7_idle", {30'd0, busy7, ld7_ready}, 32'd1);

    do_cell("ld23", 1'b0, 2, 3, 7);

    // Simultaneous requests: load first, simulation one idle cycle later.
    ld_valid = 1'b1; ld_x = 8'd1; ld_y = 8'd1; ld_colour = 3'd2;
    sim_valid = 1'b1; sim_x = 8'd5; sim_y = 8'd5; sim_colour = 3'd4;
    wait_accept("arb_ld", cyc, was_ld);
    check("arb_ld_acc", cyc * 2 + int'(was_ld), 3);
    watch_block("arb_ld", 1, 1, 2, CS * CS, -1);
    wait_accept("arb_sim", cyc, was_ld);
    check("arb_sim_acc", cyc * 2 + int'(was_ld), 2);
    watch_block("arb_sim", 5, 5, 4, CS * CS, -1);
    check_idle("arb_end", 1, 1);

    do_cell("oob_x", 1'b0, 40, 0, 5);
    do_cell("oob_y", 1'b1, 0, 30, 6);
    do_cell("edge", 1'b1, 39, 29, 3);

    // Clear pulsed mid-fill is deferred until the block ends, ahead of sim.
    ld_valid = 1'b1; ld_x = 8'd3; ld_y = 8'd4; ld_colour = 3'd1;
    sim_valid = 1'b1; sim_x = 8'd6; sim_y = 8'd7; sim_colour = 3'd6;
    wait_accept("pend_ld", cyc, was_ld);
    check("pend_ld_acc", cyc * 2 + int'(was_ld), 3);
    watch_block("pend_ld", 3, 4, 1, CS * CS, 4);
    check_idle("pend_gap", 0, 0);
    watch_clear("clr_pend");
    wait_accept("pend_sim", cyc, was_ld);
    check("pend_sim_acc", cyc * 2 + int'(was_ld), 2);
    watch_block("pend_sim", 6, 7, 6, CS * CS, -1);
    check_idle("pend_end", 1, 1);

    for (int i = 0; i < 24; i++) begin
      r_s = int'($urandom_range(0, 1));
      r_x = int'($urandom_range(0, 45));
      r_y = int'($urandom_range(0, 33));
      r_c = int'($urandom_range(0, 7));
      do_cell($sformatf("rnd%0d", i), r_s[0], r_x, r_y, r_c);
    end

    // CELL_SIZE=7 at column 22: each row plots x 154..159 and clips one cycle.
    m7x = SW - 1; m7y = SH - 1; m7c = 0;
    for (int r = 0; r < 7; r++) begin
      obs_row[r] = 0; exp_row[r] = 0;
    end
    ld7_valid = 1'b1; ld7_x = 8'd22; ld7_y = 8'd0; ld7_colour = 3'd5;
    @(negedge clock);
    check("c7_ready", {31'd0, ld7_ready}, 32'd1);
    @(posedge clock); #1;
    ld7_valid = 1'b0;
    for (int k = 0; k < 49; k++) begin
      @(negedge clock);
      cell_pixel(7, 22, 0, k, vis, px, py);
      if (vis) begin
        m7x = px; m7y = py; m7c = 5;
      end
      exp_row[k / 7] += int'(vis);
      obs_row[k / 7] += int'(v7_plot);
      check($sformatf("c7_k%0d", k), obs7(), pack(int'(vis), m7x, m7y, m7c, 1, 0, 0, 0));
      @(posedge clock); #1;
    end
    for (int r = 0; r < 7; r++) check($sformatf("c7_row%0d", r), obs_row[r], exp_row[r]);
    @(negedge clock);
    check("c7_end", obs7(), pack(0, m7x, m7y, m7c, 0, 1, 1, 0));
    @(posedge clock); #1;

    // One-cycle reset in the middle of a block restarts the sweep at (0,0).
    ld_valid = 1'b1; ld_x = 8'd7; ld_y = 8'd8; ld_colour = 3'd3;
    wait_accept("rst_ld", cyc, was_ld);
    check("rst_ld_acc", cyc * 2 + int'(was_ld), 3);
    watch_block("rst_ld", 7, 8, 3, 6, -1);
    rst_n = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(negedge clock);
    check("rst_mid", obs(), pack(0, 0, 0, 0, 1, 0, 0, 0));
    @(posedge clock); #1;
    watch_clear("clr_rst");
    check_idle("rst_end", 1, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
